// File: rtl/calc_pkg.sv
// calc_pkg: frame constants, SPI front-end states and calculator register map
package calc_pkg;
    localparam int FRAME_BITS = 16;
    localparam int HDR_BITS = 8;
    localparam logic [4:0] HDR_LAST = 5'(HDR_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
    localparam logic [6:0] ADDR_OPERAND = 7'd1;
    localparam logic [6:0] ADDR_CMD = 7'd2;
    localparam logic [6:0] ADDR_RESULT = 7'd4;
    typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DONE} state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchronizer with rise/fall pulses on the synchronized level
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end
    // Resetting to 0 means a cs_n held low across reset release is not seen as a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
    assign level = sync_q[STAGES-1];
    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;
endmodule

// File: rtl/spi_reg_if.sv
// spi_reg_if: oversampled SPI slave decoding 16-bit frames into register write/read requests
module spi_reg_if
    import calc_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);
    localparam int RX_W = ADDR_W + DATA_W - 1;
    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic mosi_s, active;
    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [RX_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic miso_q, miso_d;
    logic wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst_n(rst_n), .d(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign active = (state_q == HDR) || (state_q == WDATA) || (state_q == RDATA);

    always_comb begin
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d = state_q;
        cnt_d = cnt_q;
        rx_d = rx_q;
        tx_d = rd_req_q ? rd_data : tx_q;
        miso_d = miso_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_req_d = 1'b0;
        rd_addr_d = rd_addr_q;
        if (cs_rise) begin
            state_d = IDLE;
            miso_d = 1'b0;
        end else if (cs_fall && state_q == IDLE) begin
            state_d = HDR;
            cnt_d = '0;
        end else begin
            if (sclk_rise && state_q == RDATA) begin
                miso_d = tx_q[DATA_W-1];
                tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
            if (sclk_fall && active) begin
                rx_d = {rx_q[RX_W-2:0], mosi_s};
                cnt_d = cnt_q + 5'd1;
                // rx_q[ADDR_W-1] holds the R/W bit once seven header bits have arrived
                if (state_q == HDR && cnt_q == HDR_LAST) begin
                    state_d = rx_q[ADDR_W-1] ? RDATA : WDATA;
                    rd_req_d = rx_q[ADDR_W-1];
                    if (rx_q[ADDR_W-1])
                        rd_addr_d = {rx_q[ADDR_W-2:0], mosi_s};
                end
                if (state_q != HDR && cnt_q == FRAME_LAST) begin
                    state_d = DONE;
                    wr_en_d = (state_q == WDATA);
                    if (state_q == WDATA) begin
                        wr_addr_d = rx_q[RX_W-1:DATA_W-1];
                        wr_data_d = {rx_q[DATA_W-2:0], mosi_s};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            rx_q <= '0;
            tx_q <= '0;
            miso_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            tx_q <= tx_d;
            miso_q <= miso_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_req_q <= rd_req_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign miso = miso_q;
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_req = rd_req_q;
    assign rd_addr = rd_addr_q;
endmodule

// File: tb/tb_spi_reg_if.sv
// tb_spi_reg_if: directed SPI frames against spi_reg_if with hand-computed expectations
module tb_spi_reg_if;
    localparam int HALF = 50;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, wr_en, rd_req;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;
    int n_tests = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int dbl_cnt = 0;
    logic [14:0] wlog [$];
    logic [6:0] rd_seen = '0;
    logic wr_prev = 1'b0;
    logic rd_prev = 1'b0;
    logic [7:0] rx;

    spi_reg_if dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                wlog.push_back({wr_addr, wr_data});
            end
            if (rd_req) begin
                rd_cnt++;
                rd_seen = rd_addr;
            end
            if (wr_en && rd_req) both_cnt++;
            if ((wr_en && wr_prev) || (rd_req && rd_prev)) dbl_cnt++;
        end
        wr_prev = wr_en;
        rd_prev = rd_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [15:0] frame, input int nbits, input bit raise, output logic [7:0] r);
        r = '0;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = (i < 16) ? frame[15-i] : 1'b0;
            wait_clk(HALF);
            if (i >= 8 && i < 16) r = {r[6:0], miso};
            sclk = 1'b0;
            wait_clk(HALF);
        end
        if (raise) begin
            wait_clk(10);
            cs_n = 1'b1;
            wait_clk(20);
        end
    endtask

    initial begin
        int w0, r0;
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        wait_clk(10);

        xfer({1'b0, 7'd1, 8'h35}, 16, 1, rx);
        check("w1_cnt", wr_cnt, 1);
        check("w1_entry", wlog.pop_front(), {7'd1, 8'h35});
        check("w1_rd", rd_cnt, 0);

        xfer({1'b0, 7'd2, 8'h10}, 16, 1, rx);
        xfer({1'b0, 7'd1, 8'h11}, 16, 1, rx);
        xfer({1'b0, 7'd2, 8'h20}, 16, 1, rx);
        check("seq_cnt", wr_cnt, 4);
        check("seq_0", wlog.pop_front(), {7'd2, 8'h10});
        check("seq_1", wlog.pop_front(), {7'd1, 8'h11});
        check("seq_2", wlog.pop_front(), {7'd2, 8'h20});

        rd_data = 8'hA5;
        xfer({1'b1, 7'd4, 8'h00}, 16, 1, rx);
        check("rd_cnt", rd_cnt, 1);
        check("rd_addr", rd_seen, 4);
        check("rd_byte", rx, 8'hA5);
        check("rd_miso_idle", miso, 0);
        check("rd_no_wr", wr_cnt, 4);
        rd_data = 8'h00;

        xfer({1'b0, 7'd1, 8'hFF}, 10, 1, rx);
        check("abort_no_wr", wr_cnt, 4);
        xfer({1'b0, 7'd1, 8'h02}, 16, 1, rx);
        check("after_abort_cnt", wr_cnt, 5);
        check("after_abort_entry", wlog.pop_front(), {7'd1, 8'h02});

        xfer({1'b0, 7'd2, 8'h30}, 20, 1, rx);
        check("extra_cnt", wr_cnt, 6);
        check("extra_entry", wlog.pop_front(), {7'd2, 8'h30});

        w0 = wr_cnt;
        r0 = rd_cnt;
        xfer({1'b0, 7'd1, 8'h77}, 12, 0, rx);
        rst_n = 1'b0;
        wait_clk(5);
        check("mrst_miso", miso, 0);
        check("mrst_wr_en", wr_en, 0);
        check("mrst_wr_addr", wr_addr, 0);
        check("mrst_wr_data", wr_data, 0);
        check("mrst_rd_req", rd_req, 0);
        check("mrst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        wait_clk(5);
        for (int i = 12; i < 16; i++) begin
            sclk = 1'b1;
            mosi = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        wait_clk(10);
        cs_n = 1'b1;
        wait_clk(20);
        check("mrst_no_wr", wr_cnt, w0);
        check("mrst_no_rd", rd_cnt, r0);
        xfer({1'b0, 7'd2, 8'h5A}, 16, 1, rx);
        check("post_rst_cnt", wr_cnt, w0 + 1);
        check("post_rst_entry", wlog.pop_front(), {7'd2, 8'h5A});

        check("overlap", both_cnt, 0);
        check("multi_cycle", dbl_cnt, 0);
        check("leftover", wlog.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
